// File: rtl/baser_257b_transcoder.sv
// -----------------------------------------------------------------------------
// baser_257b_transcoder
//
// Purpose:
//   Collects four consecutive 64b/66b blocks and compresses them into one
//   256b/257b transcoded block (IEEE 802.3 Clause 91 transcoding). The result
//   is held in a single-entry output register with a ready/valid handshake.
//   Saturating statistics counters track the produced blocks.
//
// Ports:
//   clk            rising-edge clock
//   i_rst_n        synchronous active-low reset
//   i_frame        66b input block: [65:64] sync header, [63:0] payload
//   i_valid        i_frame valid
//   o_ready        block can accept i_frame this cycle
//   i_clear        discard the partially collected group
//   o_tx_coded     257b transcoded block
//   o_valid        o_tx_coded valid
//   i_ready        downstream accepts o_tx_coded
//   o_hdr_err      output group contained an invalid sync header
//   o_block_count  257b blocks produced (saturating)
//   o_ctrl_count   257b blocks with o_tx_coded[0] = 0 (saturating)
//   o_err_count    257b blocks with o_hdr_err = 1 (saturating)
// -----------------------------------------------------------------------------
module baser_257b_transcoder #(
    parameter int DATA_WIDTH        = 64,
    parameter int HDR_WIDTH         = 2,
    parameter int FRAME_WIDTH       = 66,
    parameter int TRANSCODER_BLOCKS = 4,
    parameter int TC_WIDTH          = 257
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic [FRAME_WIDTH-1:0] i_frame,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_clear,
    output logic [TC_WIDTH-1:0]    o_tx_coded,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_hdr_err,
    output logic [31:0]            o_block_count,
    output logic [31:0]            o_ctrl_count,
    output logic [31:0]            o_err_count
);

    typedef enum logic [1:0] {S0, S1, S2, S3} slot_state_e;

    slot_state_e                                 state_q;
    slot_state_e                                 fill_state;
    logic [TRANSCODER_BLOCKS-2:0][FRAME_WIDTH-1:0] slot_q;
    logic [TC_WIDTH-1:0]                         tx_coded_q;
    logic                                        valid_q;
    logic                                        hdr_err_q;
    logic [31:0]                                 block_count_q;
    logic [31:0]                                 ctrl_count_q;
    logic [31:0]                                 err_count_q;

    logic                                        accept;
    logic                                        load;
    logic [TRANSCODER_BLOCKS-1:0][FRAME_WIDTH-1:0] grp;
    logic [TRANSCODER_BLOCKS-1:0][DATA_WIDTH-1:0]  pay;
    logic [TRANSCODER_BLOCKS-1:0][DATA_WIDTH-5:0]  cmp;
    logic [TRANSCODER_BLOCKS-1:0]                d_flag;
    logic [TRANSCODER_BLOCKS-1:0]                bad_hdr;
    logic [TC_WIDTH-6:0]                         body;
    logic [TC_WIDTH-1:0]                         coded_d;
    logic                                        hdr_err_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    assign o_ready = !valid_q || i_ready;
    assign accept  = i_valid && o_ready;
    // A clear in the same cycle as an accept restarts the group at slot 0.
    assign fill_state = i_clear ? S0 : state_q;
    assign load       = accept && (fill_state == S3);

    // The fourth block is taken straight from the input, so the group is
    // encoded in the same cycle it completes.
    assign grp = {i_frame, slot_q[2], slot_q[1], slot_q[0]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves a value unassigned (no latch inferred).
        pay     = '0;
        cmp     = '0;
        d_flag  = '0;
        bad_hdr = '0;
        body    = '0;
        coded_d = '0;
        for (int k = 0; k < TRANSCODER_BLOCKS; k++) begin
            pay[k]     = grp[k][DATA_WIDTH-1:0];
            d_flag[k]  = (grp[k][FRAME_WIDTH-1 -: HDR_WIDTH] == 2'b01);
            // 2'b00 and 2'b11 are invalid; they are coded as control.
            bad_hdr[k] = (grp[k][FRAME_WIDTH-1] == grp[k][FRAME_WIDTH-2]);
            // Compressed first control block: type[7:4] then payload[63:8].
            cmp[k]     = {grp[k][DATA_WIDTH-1:8], grp[k][7:4]};
        end
        if (&d_flag) begin
            coded_d = {pay[3], pay[2], pay[1], pay[0], 1'b1};
        end else begin
            if (!d_flag[0])      body = {pay[3], pay[2], pay[1], cmp[0]};
            else if (!d_flag[1]) body = {pay[3], pay[2], cmp[1], pay[0]};
            else if (!d_flag[2]) body = {pay[3], cmp[2], pay[1], pay[0]};
            else                 body = {cmp[3], pay[2], pay[1], pay[0]};
            coded_d = {body, d_flag, 1'b0};
        end
        hdr_err_d = |bad_hdr;
    end

    // Slot counter, slot storage, output register and counters.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            // NOTE: slot storage is reset too, so a group abandoned by reset
            // never leaks stale payload into a later output.
            state_q       <= S0;
            slot_q        <= '0;
            tx_coded_q    <= '0;
            valid_q       <= 1'b0;
            hdr_err_q     <= 1'b0;
            block_count_q <= '0;
            ctrl_count_q  <= '0;
            err_count_q   <= '0;
        end else begin
            // NOTE: all state updates are non-blocking so every register
            // samples the pre-edge values regardless of statement order.
            if (accept) begin
                unique case (fill_state)
                    S0: begin slot_q[0] <= i_frame; state_q <= S1; end
                    S1: begin slot_q[1] <= i_frame; state_q <= S2; end
                    S2: begin slot_q[2] <= i_frame; state_q <= S3; end
                    S3: begin state_q <= S0; end
                    default: state_q <= S0;
                endcase
            end else if (i_clear) begin
                state_q <= S0;
            end

            if (load) begin
                tx_coded_q    <= coded_d;
                hdr_err_q     <= hdr_err_d;
                valid_q       <= 1'b1;
                block_count_q <= sat_inc(block_count_q, 1'b1);
                ctrl_count_q  <= sat_inc(ctrl_count_q, !coded_d[0]);
                err_count_q   <= sat_inc(err_count_q, hdr_err_d);
            end else if (i_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_tx_coded    = tx_coded_q;
    assign o_valid       = valid_q;
    assign o_hdr_err     = hdr_err_q;
    assign o_block_count = block_count_q;
    assign o_ctrl_count  = ctrl_count_q;
    assign o_err_count   = err_count_q;

endmodule

// File: tb/tb_baser_257b_transcoder.sv
// -----------------------------------------------------------------------------
// tb_baser_257b_transcoder
//
// Self-checking bench for baser_257b_transcoder. A behavioural model (queues
// plus a bit-by-bit packer) predicts every output block and counter value;
// directed scenarios add literal expectations, then randomized traffic with
// random gaps, backpressure and clears runs against the same model.
// -----------------------------------------------------------------------------
module tb_baser_257b_transcoder;

    logic         clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [65:0]  i_frame = '0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic         i_clear = 1'b0;
    logic [256:0] o_tx_coded;
    logic         o_valid;
    logic         i_ready = 1'b1;
    logic         o_hdr_err;
    logic [31:0]  o_block_count;
    logic [31:0]  o_ctrl_count;
    logic [31:0]  o_err_count;

    always #5 clk = ~clk;

    baser_257b_transcoder dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_frame       (i_frame),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_clear       (i_clear),
        .o_tx_coded    (o_tx_coded),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_hdr_err     (o_hdr_err),
        .o_block_count (o_block_count),
        .o_ctrl_count  (o_ctrl_count),
        .o_err_count   (o_err_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [65:0]  grp_q[$];
    logic [256:0] exp_code_q[$];
    logic         exp_err_q[$];
    logic [31:0]  m_blocks = '0;
    logic [31:0]  m_ctrl   = '0;
    logic [31:0]  m_errs   = '0;
    bit           rand_ready = 0;

    function automatic bit is_data(input logic [65:0] f);
        return f[65:64] == 2'b01;
    endfunction

    // Packs the group bit by bit following the transcoding rules.
    function automatic logic [256:0] ref_encode(input logic [65:0] b0, input logic [65:0] b1,
                                               input logic [65:0] b2, input logic [65:0] b3);
        logic [65:0]  b[4];
        logic [256:0] r;
        int           pos;
        bit           seen;
        bit           all_d;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        r = '0;
        all_d = 1;
        for (int k = 0; k < 4; k++) if (!is_data(b[k])) all_d = 0;
        if (all_d) begin
            r[0] = 1'b1;
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 64; i++) r[1 + 64*k + i] = b[k][i];
        end else begin
            r[0] = 1'b0;
            for (int k = 0; k < 4; k++) r[1 + k] = is_data(b[k]);
            pos  = 5;
            seen = 0;
            for (int k = 0; k < 4; k++) begin
                if (!seen && !is_data(b[k])) begin
                    // type[7:4] followed by payload[63:8]: bits 4..63 in order
                    for (int i = 4; i < 64; i++) begin r[pos] = b[k][i]; pos++; end
                    seen = 1;
                end else begin
                    for (int i = 0; i < 64; i++) begin r[pos] = b[k][i]; pos++; end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] m_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    // Compare DUT state against the model, then advance the model by the
    // events that the coming rising edge will perform.
    always @(negedge clk) begin
        bit           acc;
        bit           hs;
        logic [256:0] code;
        bit           err;
        check("o_valid", o_valid, exp_code_q.size() != 0);
        check("o_ready", o_ready, (exp_code_q.size() != 0) ? i_ready : 1'b1);
        if (exp_code_q.size() != 0) begin
            check("o_tx_coded", o_tx_coded, exp_code_q[0]);
            check("o_hdr_err", o_hdr_err, exp_err_q[0]);
        end
        check("o_block_count", o_block_count, m_blocks);
        check("o_ctrl_count", o_ctrl_count, m_ctrl);
        check("o_err_count", o_err_count, m_errs);

        if (!i_rst_n) begin
            grp_q.delete();
            exp_code_q.delete();
            exp_err_q.delete();
            m_blocks = '0;
            m_ctrl   = '0;
            m_errs   = '0;
        end else begin
            hs  = (exp_code_q.size() != 0) && i_ready;
            acc = i_valid && ((exp_code_q.size() == 0) || i_ready);
            if (hs) begin
                void'(exp_code_q.pop_front());
                void'(exp_err_q.pop_front());
            end
            if (i_clear) grp_q.delete();
            if (acc) begin
                grp_q.push_back(i_frame);
                if (grp_q.size() == 4) begin
                    code = ref_encode(grp_q[0], grp_q[1], grp_q[2], grp_q[3]);
                    err  = 0;
                    for (int k = 0; k < 4; k++)
                        if (grp_q[k][65] == grp_q[k][64]) err = 1;
                    exp_code_q.push_back(code);
                    exp_err_q.push_back(err);
                    m_blocks = m_inc(m_blocks);
                    if (!code[0]) m_ctrl = m_inc(m_ctrl);
                    if (err) m_errs = m_inc(m_errs);
                    grp_q.delete();
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [65:0] f);
        bit acc;
        int n;
        acc = 0;
        n   = 0;
        i_valid = 1'b1;
        i_frame = f;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = o_ready;
            tick();
            n++;
        end
        i_valid = 1'b0;
        check("accept_timeout", acc, 1'b1);
    endtask

    function automatic logic [65:0] dat(input logic [63:0] p);
        return {2'b01, p};
    endfunction

    function automatic logic [65:0] ctl(input logic [63:0] p);
        return {2'b10, p};
    endfunction

    logic [63:0]  p0, p1, p2, p3, q0, q1, q2, q3;
    logic [256:0] e1;

    initial begin
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();

        // All data
        for (int k = 0; k < 4; k++) send(dat(64'hAAAA_AAAA_AAAA_AAAA));
        check("t1_valid", o_valid, 1'b1);
        check("t1_code", o_tx_coded, {{4{64'hAAAA_AAAA_AAAA_AAAA}}, 1'b1});
        check("t1_blocks", o_block_count, 32'd1);
        check("t1_ctrl", o_ctrl_count, 32'd0);

        // Control in slot 0
        send(ctl({56'h0, 8'h1E}));
        for (int k = 0; k < 3; k++) send(dat(64'h5555_5555_5555_5555));
        check("t2_code", o_tx_coded, {{3{64'h5555_5555_5555_5555}}, 56'h0, 4'h1, 4'b1110, 1'b0});
        check("t2_ctrl", o_ctrl_count, 32'd1);

        // Control in slot 2
        p0 = 64'h0123_4567_89AB_CDEF;
        p1 = 64'hFEDC_BA98_7654_3210;
        p2 = {56'h11_2233_4455_6677, 8'h78};
        p3 = 64'hDEAD_BEEF_CAFE_F00D;
        send(dat(p0)); send(dat(p1)); send(ctl(p2)); send(dat(p3));
        check("t3_code", o_tx_coded, {p3, p2[63:8], 4'h7, p1, p0, 4'b1011, 1'b0});
        check("t3_ctrl", o_ctrl_count, 32'd2);

        // Invalid header in slot 1
        send(dat(p0)); send({2'b00, p1}); send(dat(p2)); send(dat(p3));
        check("t4_hdr_err", o_hdr_err, 1'b1);
        check("t4_bit2", o_tx_coded[2], 1'b0);
        check("t4_errs", o_err_count, 32'd1);

        // Backpressure
        send(dat(p3)); send(dat(p2)); send(dat(p1)); send(dat(p0));
        e1 = {p0, p1, p2, p3, 1'b1};
        i_ready = 1'b0;
        q0 = 64'h1111_2222_3333_4444; q1 = 64'h5555_6666_7777_8888;
        q2 = {56'hAB_CDEF_0123_4567, 8'h2D}; q3 = 64'h9999_AAAA_BBBB_CCCC;
        i_valid = 1'b1;
        i_frame = dat(q0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_ready_low", o_ready, 1'b0);
            check("t5_hold", o_tx_coded, e1);
            tick();
        end
        i_ready = 1'b1;
        send(dat(q0)); send(dat(q1)); send(ctl(q2)); send(dat(q3));
        check("t5_code2", o_tx_coded, {q3, q2[63:8], q2[7:4], q1, q0, 4'b1011, 1'b0});
        check("t5_blocks", o_block_count, 32'd6);

        // Clear between groups, then clear together with an accept
        send(ctl(q0)); send(dat(q1));
        i_clear = 1'b1;
        tick();
        send(dat(p0)); send(dat(p1)); send(dat(p2)); send(dat(p3));
        check("t6_code", o_tx_coded, {p3, p2, p1, p0, 1'b1});
        check("t6_blocks", o_block_count, 32'd7);
        send(ctl(q3));
        i_clear = 1'b1;
        send(dat(q0)); send(dat(q1)); send(dat(q2)); send(dat(q3));
        check("t6_clear_acc", o_tx_coded, {q3, q2, q1, q0, 1'b1});
        check("t6_blocks2", o_block_count, 32'd8);

        // Reset mid-group
        send(ctl(p0)); send(ctl(p1));
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        check("t7_valid", o_valid, 1'b0);
        check("t7_code", o_tx_coded, 257'd0);
        check("t7_hdr_err", o_hdr_err, 1'b0);
        check("t7_blocks", o_block_count, 32'd0);
        check("t7_ctrl", o_ctrl_count, 32'd0);
        check("t7_errs", o_err_count, 32'd0);
        send(dat(q3)); send(dat(q2)); send(dat(q1)); send(dat(q0));
        check("t7_code2", o_tx_coded, {q0, q1, q2, q3, 1'b1});
        check("t7_blocks2", o_block_count, 32'd1);

        // Randomized traffic
        rand_ready = 1;
        for (int n = 0; n < 600; n++) begin
            int unsigned sel;
            logic [1:0]  hdr;
            sel = $urandom_range(0, 9);
            if (sel < 6)      hdr = 2'b01;
            else if (sel < 9) hdr = 2'b10;
            else              hdr = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            if ($urandom_range(0, 3) == 0) tick();
            if ($urandom_range(0, 39) == 0) i_clear = 1'b1;
            send({hdr, $urandom(), $urandom()});
        end
        rand_ready = 0;
        i_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("drained", exp_code_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
